arbitro_compuerta_parqueo: RTL and testbench

- Shares the single parking barrier between the entry lane (driven by the access/PIN controller's gate request) and the exit lane.
- Arbitrates simultaneous requests, tracks lot occupancy and blocks entry when the lot is full.
- Raises an alarm if an open gate is not crossed within a timeout.
- Sits between the access controller and the barrier actuator driver.

---
 rtl/parqueo_pkg.sv | 34 +++
 rtl/arbitro_compuerta_parqueo_if.sv | 28 ++
 rtl/contador_ocupacion.sv | 39 +++
 rtl/arbitro_compuerta_parqueo.sv | 112 +++++++++++
 tb/tb_arbitro_compuerta_parqueo.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parqueo_pkg.sv
// Shared definitions for the parking-gate arbiter and the access controller:
// one-hot FSM states, lane encodings and default lot/timeout constants.
package parqueo_pkg;

    localparam int unsigned CAPACIDAD_DEF       = 8;
    localparam int unsigned TIEMPO_APERTURA_DEF = 20;

    localparam logic [4:0] EST_LIBRE             = 5'b00001;
    localparam logic [4:0] EST_ABIERTA_ENTRADA   = 5'b00010;
    localparam logic [4:0] EST_ABIERTA_SALIDA    = 5'b00100;
    localparam logic [4:0] EST_ESPERA_LIBERACION = 5'b01000;
    localparam logic [4:0] EST_ALARMA_TIEMPO     = 5'b10000;

    typedef enum logic [4:0] {
        StLibre            = EST_LIBRE,
        StAbiertaEntrada   = EST_ABIERTA_ENTRADA,
        StAbiertaSalida    = EST_ABIERTA_SALIDA,
        StEsperaLiberacion = EST_ESPERA_LIBERACION,
        StAlarmaTiempo     = EST_ALARMA_TIEMPO
    } estado_t;

    localparam logic ENTRADA = 1'b0;
    localparam logic SALIDA  = 1'b1;

    typedef enum logic {
        CarrilEntrada = ENTRADA,
        CarrilSalida  = SALIDA
    } carril_t;

    function automatic logic es_abierta(estado_t estado);
        return (estado == StAbiertaEntrada) || (estado == StAbiertaSalida);
    endfunction

endpackage

// File: rtl/arbitro_compuerta_parqueo_if.sv
// Gate-arbiter bus: lane requests and crossing sensor in, barrier command and
// lot status out. master = access controller side, slave = arbiter.
interface arbitro_compuerta_parqueo_if #(
    parameter int unsigned ANCHO_OCUPACION = 4
);
    logic                       solicitud_entrada;
    logic                       solicitud_salida;
    logic                       bloqueo_entrada;
    logic                       sensor_paso;
    logic                       abrir_compuerta;
    logic                       concesion_entrada;
    logic                       concesion_salida;
    logic                       parqueo_lleno;
    logic [ANCHO_OCUPACION-1:0] ocupacion;
    logic                       alarma_tiempo;

    modport master (
        output solicitud_entrada, solicitud_salida, bloqueo_entrada, sensor_paso,
        input  abrir_compuerta, concesion_entrada, concesion_salida, parqueo_lleno,
        input  ocupacion, alarma_tiempo
    );

    modport slave (
        input  solicitud_entrada, solicitud_salida, bloqueo_entrada, sensor_paso,
        output abrir_compuerta, concesion_entrada, concesion_salida, parqueo_lleno,
        output ocupacion, alarma_tiempo
    );
endinterface

// File: rtl/contador_ocupacion.sv
// Saturating up/down occupancy counter: clamps at CAPACIDAD and at zero.
module contador_ocupacion #(
    parameter int unsigned CAPACIDAD       = 8,
    parameter int unsigned ANCHO_OCUPACION = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       incrementar,
    input  logic                       decrementar,
    output logic [ANCHO_OCUPACION-1:0] ocupacion,
    output logic                       lleno,
    output logic                       vacio
);
    localparam logic [ANCHO_OCUPACION-1:0] MAXIMO = ANCHO_OCUPACION'(CAPACIDAD);

    logic [ANCHO_OCUPACION-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (incrementar && !decrementar && (cuenta_q < MAXIMO)) begin
            cuenta_d = cuenta_q + 1'b1;
        end else if (decrementar && !incrementar && (cuenta_q != '0)) begin
            cuenta_d = cuenta_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign ocupacion = cuenta_q;
    assign lleno     = (cuenta_q >= MAXIMO);
    assign vacio     = (cuenta_q == '0);

endmodule

// File: rtl/arbitro_compuerta_parqueo.sv
// Arbitrates the single parking barrier between entry and exit lanes, tracks
// occupancy and raises an alarm when an opened gate is not crossed in time.
module arbitro_compuerta_parqueo
    import parqueo_pkg::*;
#(
    parameter int unsigned CAPACIDAD       = CAPACIDAD_DEF,
    parameter int unsigned ANCHO_OCUPACION = 4,
    parameter int unsigned TIEMPO_APERTURA = TIEMPO_APERTURA_DEF,
    parameter int unsigned ANCHO_TIEMPO    = 5
) (
    input logic                        clock,
    input logic                        reset,
    arbitro_compuerta_parqueo_if.slave bus
);
    localparam logic [ANCHO_TIEMPO-1:0] LIMITE = ANCHO_TIEMPO'(TIEMPO_APERTURA - 1);

    estado_t                  estado_q, estado_d;
    carril_t                  ultimo_q, ultimo_d;
    logic [ANCHO_TIEMPO-1:0]  tiempo_q, tiempo_d;
    logic                     sensor_previo_q;
    logic                     flanco_q, flanco_d;

    logic                       incrementar, decrementar;
    logic                       lleno, vacio;
    logic [ANCHO_OCUPACION-1:0] ocupacion;
    logic                       elegible_entrada, elegible_salida;
    logic                       solicitud_servida;

    assign elegible_entrada  = bus.solicitud_entrada && !bus.bloqueo_entrada && !lleno;
    assign elegible_salida   = bus.solicitud_salida && !vacio;
    assign solicitud_servida = (ultimo_q == CarrilEntrada) ? bus.solicitud_entrada
                                                           : bus.solicitud_salida;

    // Crossings only count while the gate is open; the registered edge adds one cycle.
    assign flanco_d = bus.sensor_paso && !sensor_previo_q && es_abierta(estado_q);

    always_comb begin
        estado_d    = estado_q;
        ultimo_d    = ultimo_q;
        tiempo_d    = tiempo_q;
        incrementar = 1'b0;
        decrementar = 1'b0;
        unique case (estado_q)
            StLibre: begin
                if (elegible_entrada && (!elegible_salida || ultimo_q == CarrilSalida)) begin
                    estado_d = StAbiertaEntrada;
                    ultimo_d = CarrilEntrada;
                    tiempo_d = '0;
                end else if (elegible_salida) begin
                    estado_d = StAbiertaSalida;
                    ultimo_d = CarrilSalida;
                    tiempo_d = '0;
                end
            end
            StAbiertaEntrada, StAbiertaSalida: begin
                // A crossing beats a timeout landing on the same edge.
                if (flanco_q) begin
                    incrementar = (estado_q == StAbiertaEntrada);
                    decrementar = (estado_q == StAbiertaSalida);
                    estado_d    = StEsperaLiberacion;
                end else if (tiempo_q == LIMITE) begin
                    estado_d = StAlarmaTiempo;
                end else begin
                    tiempo_d = tiempo_q + 1'b1;
                end
            end
            StEsperaLiberacion, StAlarmaTiempo: begin
                if (!solicitud_servida) begin
                    estado_d = StLibre;
                end
            end
            default: estado_d = StLibre;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q        <= StLibre;
            ultimo_q        <= CarrilSalida;
            tiempo_q        <= '0;
            sensor_previo_q <= 1'b0;
            flanco_q        <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            ultimo_q        <= ultimo_d;
            tiempo_q        <= tiempo_d;
            sensor_previo_q <= bus.sensor_paso;
            flanco_q        <= flanco_d;
        end
    end

    contador_ocupacion #(
        .CAPACIDAD       (CAPACIDAD),
        .ANCHO_OCUPACION (ANCHO_OCUPACION)
    ) u_contador (
        .clock       (clock),
        .reset       (reset),
        .incrementar (incrementar),
        .decrementar (decrementar),
        .ocupacion   (ocupacion),
        .lleno       (lleno),
        .vacio       (vacio)
    );

    assign bus.abrir_compuerta   = es_abierta(estado_q);
    assign bus.concesion_entrada = (estado_q == StAbiertaEntrada);
    assign bus.concesion_salida  = (estado_q == StAbiertaSalida);
    assign bus.alarma_tiempo     = (estado_q == StAlarmaTiempo);
    assign bus.parqueo_lleno     = lleno;
    assign bus.ocupacion         = ocupacion;

endmodule

// File: tb/tb_arbitro_compuerta_parqueo.sv
// Bench for arbitro_compuerta_parqueo: directed scenarios plus random traffic,
// every cycle compared against a lot/gate model kept in the bench.
module tb_arbitro_compuerta_parqueo;
    localparam int CAP = 8;
    localparam int TMAX = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    arbitro_compuerta_parqueo_if #(.ANCHO_OCUPACION(4)) bus ();

    arbitro_compuerta_parqueo #(
        .CAPACIDAD       (CAP),
        .ANCHO_OCUPACION (4),
        .TIEMPO_APERTURA (TMAX),
        .ANCHO_TIEMPO    (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int pruebas = 0;
    int fallos = 0;

    task automatic comprobar(input string nombre, input logic [31:0] actual,
                             input logic [31:0] esperado);
        pruebas++;
        if (actual !== esperado) begin
            fallos++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nombre, actual, esperado, $time);
        end
    endtask

    // Model: gate mode 0 idle, 1 open, 2 waiting for release, 3 alarm.
    int   m_modo = 0;
    int   m_duenio = 0;      // 1 entry, 2 exit
    int   m_servido = 2;
    int   m_abierto = 0;     // cycles the gate has been open so far
    int   m_occ = 0;
    logic m_prev = 1'b0;
    logic m_pend = 1'b0;
    bit   armado = 1'b0;

    always @(posedge clock) begin
        int   modo, duenio, servido, abierto, occ, elegido;
        logic pend, req;
        if (!reset) begin
            armado    <= 1'b1;
            m_modo    <= 0;
            m_duenio  <= 0;
            m_servido <= 2;
            m_abierto <= 0;
            m_occ     <= 0;
            m_prev    <= 1'b0;
            m_pend    <= 1'b0;
        end else begin
            modo = m_modo; duenio = m_duenio; servido = m_servido;
            abierto = m_abierto; occ = m_occ;
            pend = bus.sensor_paso && !m_prev && (m_modo == 1);
            if (m_modo == 0) begin
                elegido = 0;
                if (bus.solicitud_entrada && !bus.bloqueo_entrada && m_occ < CAP) elegido = 1;
                if (bus.solicitud_salida && m_occ > 0)
                    elegido = (elegido == 1 && m_servido == 1) ? 2 : (elegido == 1 ? 1 : 2);
                if (elegido != 0) begin
                    modo = 1; duenio = elegido; servido = elegido; abierto = 1;
                end
            end else if (m_modo == 1) begin
                if (m_pend) begin
                    occ = (m_duenio == 1) ? ((occ < CAP) ? occ + 1 : occ)
                                          : ((occ > 0) ? occ - 1 : occ);
                    modo = 2;
                end else if (m_abierto == TMAX) begin
                    modo = 3;
                end else begin
                    abierto = m_abierto + 1;
                end
            end else begin
                req = (m_servido == 1) ? bus.solicitud_entrada : bus.solicitud_salida;
                if (!req) modo = 0;
            end
            m_modo <= modo; m_duenio <= duenio; m_servido <= servido;
            m_abierto <= abierto; m_occ <= occ;
            m_prev <= bus.sensor_paso; m_pend <= pend;
        end
    end

    always @(negedge clock) begin
        if (armado) begin
            comprobar("abrir_compuerta", bus.abrir_compuerta, 32'(m_modo == 1));
            comprobar("concesion_entrada", bus.concesion_entrada,
                      32'(m_modo == 1 && m_duenio == 1));
            comprobar("concesion_salida", bus.concesion_salida,
                      32'(m_modo == 1 && m_duenio == 2));
            comprobar("alarma_tiempo", bus.alarma_tiempo, 32'(m_modo == 3));
            comprobar("parqueo_lleno", bus.parqueo_lleno, 32'(m_occ == CAP));
            comprobar("ocupacion", bus.ocupacion, 32'(m_occ));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cruzar();
        bus.sensor_paso = 1'b1;
        tick();
        bus.sensor_paso = 1'b0;
        tick();
    endtask

    task automatic servir_entrada();
        bus.solicitud_entrada = 1'b1;
        tick();
        comprobar("lit_grant_entrada", bus.concesion_entrada, 1);
        cruzar();
        bus.solicitud_entrada = 1'b0;
        tick();
    endtask

    task automatic servir_salida();
        bus.solicitud_salida = 1'b1;
        tick();
        comprobar("lit_grant_salida", bus.concesion_salida, 1);
        cruzar();
        bus.solicitud_salida = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        bus.solicitud_entrada = 1'b1;
        bus.solicitud_salida  = 1'b1;
        bus.bloqueo_entrada   = 1'b1;
        bus.sensor_paso       = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        comprobar("lit_reset_abrir", bus.abrir_compuerta, 0);
        comprobar("lit_reset_alarma", bus.alarma_tiempo, 0);
        comprobar("lit_reset_ocupacion", bus.ocupacion, 0);

        reset = 1'b1;
        bus.bloqueo_entrada  = 1'b0;
        bus.sensor_paso      = 1'b0;
        bus.solicitud_salida = 1'b0;
        tick();
        comprobar("lit_post_reset_grant", bus.concesion_entrada, 1);
        repeat (3) tick();
        bus.sensor_paso = 1'b1;
        tick();
        bus.sensor_paso = 1'b0;
        comprobar("lit_gate_still_open", bus.abrir_compuerta, 1);
        tick();
        comprobar("lit_single_ocupacion", bus.ocupacion, 1);
        comprobar("lit_single_closed", bus.abrir_compuerta, 0);
        repeat (5) tick();
        comprobar("lit_no_regrant", bus.abrir_compuerta, 0);
        bus.solicitud_entrada = 1'b0;
        tick();

        repeat (3) servir_entrada();
        servir_salida();
        comprobar("lit_occ_three", bus.ocupacion, 3);
        bus.solicitud_entrada = 1'b1;
        bus.solicitud_salida  = 1'b1;
        tick();
        comprobar("lit_both_entry_first", bus.concesion_entrada, 1);
        cruzar();
        bus.solicitud_entrada = 1'b0;
        bus.solicitud_salida  = 1'b0;
        tick();
        bus.solicitud_entrada = 1'b1;
        bus.solicitud_salida  = 1'b1;
        tick();
        comprobar("lit_both_exit_second", bus.concesion_salida, 1);
        cruzar();
        comprobar("lit_occ_back_three", bus.ocupacion, 3);
        bus.solicitud_entrada = 1'b0;
        bus.solicitud_salida  = 1'b0;
        tick();

        repeat (5) servir_entrada();
        comprobar("lit_full", bus.parqueo_lleno, 1);
        bus.solicitud_entrada = 1'b1;
        repeat (50) tick();
        comprobar("lit_full_blocks_entry", bus.abrir_compuerta, 0);
        bus.solicitud_salida = 1'b1;
        tick();
        comprobar("lit_full_exit_grant", bus.concesion_salida, 1);
        cruzar();
        comprobar("lit_occ_seven", bus.ocupacion, 7);
        bus.solicitud_salida = 1'b0;
        tick();
        tick();
        comprobar("lit_entry_after_exit", bus.concesion_entrada, 1);
        cruzar();
        bus.solicitud_entrada = 1'b0;
        tick();

        bus.solicitud_salida = 1'b1;
        tick();
        n = 0;
        while (bus.abrir_compuerta === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        comprobar("lit_open_cycles", n, TMAX);
        comprobar("lit_alarm_raised", bus.alarma_tiempo, 1);
        comprobar("lit_alarm_occ", bus.ocupacion, 8);
        bus.solicitud_salida = 1'b0;
        tick();
        comprobar("lit_alarm_cleared", bus.alarma_tiempo, 0);

        bus.bloqueo_entrada   = 1'b1;
        bus.solicitud_entrada = 1'b1;
        repeat (5) tick();
        comprobar("lit_lock_blocks", bus.abrir_compuerta, 0);
        bus.solicitud_salida = 1'b1;
        tick();
        comprobar("lit_lock_exit_opens", bus.concesion_salida, 1);
        reset = 1'b0;
        tick();
        comprobar("lit_midopen_reset_gate", bus.abrir_compuerta, 0);
        comprobar("lit_midopen_reset_occ", bus.ocupacion, 0);
        reset = 1'b1;
        bus.solicitud_entrada = 1'b0;
        bus.solicitud_salida  = 1'b0;
        bus.bloqueo_entrada   = 1'b0;
        tick();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.solicitud_entrada = ~bus.solicitud_entrada;
            if ($urandom_range(0, 7) == 0) bus.solicitud_salida = ~bus.solicitud_salida;
            if ($urandom_range(0, 31) == 0) bus.bloqueo_entrada = ~bus.bloqueo_entrada;
            bus.sensor_paso = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 599) != 0);
            tick();
        end
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
        $finish;
    end

endmodule
